multicycle_control: RTL and testbench

//  Multicycle control FSM for the 32-bit datapath. Fetches and decodes each instruction,

---
 rtl/ctrl_pkg.sv | 73 +++++++
 rtl/instr_decoder.sv | 77 +++++++
 rtl/multicycle_control.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants and types for the multicycle control FSM: ALU op codes,
// instruction opcodes, state encoding, error codes and the decode record.
package ctrl_pkg;

  // ALU operation codes driven on ALU_func
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_NOT = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRL = 4'b1010;
  localparam logic [3:0] ALU_ROL = 4'b1100;
  localparam logic [3:0] ALU_ROR = 4'b1101;

  // Instruction opcodes (Instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;

  // R-type instructions carry 2'b11 in func[5:4]
  localparam logic [1:0] FUNC_RTYPE_HI = 2'b11;

  // FSM state encoding
  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_DEC = 3'd1;
  localparam logic [2:0] S_EXE = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;
  localparam logic [2:0] S_BR  = 3'd5;
  localparam logic [2:0] S_ERR = 3'd6;

  // Err_code values
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Instruction class, chooses the state path after decode
  typedef enum logic [2:0] {
    CLS_ALU = 3'd0,
    CLS_LW  = 3'd1,
    CLS_SW  = 3'd2,
    CLS_B   = 3'd3,
    CLS_BEQ = 3'd4,
    CLS_BNE = 3'd5
  } instr_class_t;

  // Everything the FSM needs to know about one instruction
  typedef struct packed {
    instr_class_t cls;
    logic [3:0]   alu_func;
    logic         imm_ext_sel;
    logic         alu_bin_sel;
    logic         legal;
  } decode_t;

  function automatic logic is_branch(input instr_class_t c);
    return (c == CLS_B) || (c == CLS_BEQ) || (c == CLS_BNE);
  endfunction

  function automatic logic is_mem_op(input instr_class_t c);
    return (c == CLS_LW) || (c == CLS_SW);
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: opcode/func to class, ALU op,
// immediate-extension and ALU B-input selects, plus a legality flag.
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output decode_t    dec
);

  // Only these ALU codes exist; the remaining six encodings are illegal
  function automatic logic alu_code_legal(input logic [3:0] code);
    case (code)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOT,
      ALU_SRA, ALU_SLL, ALU_SRL, ALU_ROL, ALU_ROR: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

  // Opcode table; anything not listed stays illegal
  always_comb begin
    dec.cls         = CLS_ALU;
    dec.alu_func    = ALU_ADD;
    dec.imm_ext_sel = 1'b0;
    dec.alu_bin_sel = 1'b0;
    dec.legal       = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec.alu_func = func[3:0];
        dec.legal    = (func[5:4] == FUNC_RTYPE_HI) && alu_code_legal(func[3:0]);
      end
      OP_LI, OP_ADDI: begin
        dec.alu_bin_sel = 1'b1;
        dec.legal       = 1'b1;
      end
      OP_ANDI: begin
        dec.alu_func    = ALU_AND;
        dec.imm_ext_sel = 1'b1;
        dec.alu_bin_sel = 1'b1;
        dec.legal       = 1'b1;
      end
      OP_ORI: begin
        dec.alu_func    = ALU_OR;
        dec.imm_ext_sel = 1'b1;
        dec.alu_bin_sel = 1'b1;
        dec.legal       = 1'b1;
      end
      OP_LW: begin
        dec.cls         = CLS_LW;
        dec.alu_bin_sel = 1'b1;
        dec.legal       = 1'b1;
      end
      OP_SW: begin
        dec.cls         = CLS_SW;
        dec.alu_bin_sel = 1'b1;
        dec.legal       = 1'b1;
      end
      OP_B: begin
        dec.cls      = CLS_B;
        dec.alu_func = ALU_SUB;
        dec.legal    = 1'b1;
      end
      OP_BEQ: begin
        dec.cls      = CLS_BEQ;
        dec.alu_func = ALU_SUB;
        dec.legal    = 1'b1;
      end
      OP_BNE: begin
        dec.cls      = CLS_BNE;
        dec.alu_func = ALU_SUB;
        dec.legal    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: sequences fetch, decode, execute, memory, write-back
// and branch states, times out stalled memory accesses and latches errors.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        Mem_Ack,
  output logic        Mem_Req,
  output logic        Mem_WrEn,
  output logic        Instr_LdEn,
  output logic        PC_LdEn,
  output logic        PC_sel,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        RF_B_sel,
  output logic        ALU_Bin_sel,
  output logic        ImmExt_sel,
  output logic [3:0]  ALU_func,
  output logic        Error,
  output logic [1:0]  Err_code
);

  localparam int            CW        = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  logic [2:0]    state_reg, state_next;
  logic [CW-1:0] wait_reg;
  decode_t       dec_now, dec_reg;
  logic          error_reg;
  logic [1:0]    err_code_reg;
  logic          in_mem_wait;
  logic          timeout;
  logic          branch_taken;

  // Instr bits between opcode and func are datapath fields, not control
  logic unused_fields;
  assign unused_fields = ^{Instr[25:6], dec_reg.legal};

  instr_decoder u_decoder (
    .opcode (Instr[31:26]),
    .func   (Instr[5:0]),
    .dec    (dec_now)
  );

  assign in_mem_wait  = (state_reg == S_IF) || (state_reg == S_MEM);
  assign timeout      = in_mem_wait && !Mem_Ack && (wait_reg == WAIT_LAST);
  assign branch_taken = (dec_reg.cls == CLS_B) ||
                        ((dec_reg.cls == CLS_BEQ) && Zero) ||
                        ((dec_reg.cls == CLS_BNE) && !Zero);

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= S_IF;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; an ack in the terminal wait cycle beats the timeout
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IF: begin
        if (Mem_Ack)      state_next = S_DEC;
        else if (timeout) state_next = S_ERR;
      end
      S_DEC: begin
        if (!dec_now.legal)              state_next = S_ERR;
        else if (is_branch(dec_now.cls)) state_next = S_BR;
        else                             state_next = S_EXE;
      end
      S_EXE:   state_next = is_mem_op(dec_reg.cls) ? S_MEM : S_WB;
      S_MEM: begin
        if (Mem_Ack)      state_next = (dec_reg.cls == CLS_SW) ? S_IF : S_WB;
        else if (timeout) state_next = S_ERR;
      end
      S_WB:    state_next = S_IF;
      S_BR:    state_next = S_IF;
      S_ERR:   state_next = S_ERR;
      default: state_next = S_ERR;
    endcase
  end

  // Decoded fields latched in S_DEC drive every later state of the instruction
  always_ff @(posedge Clk) begin
    if (Reset) begin
      dec_reg <= '0;
    end else if (state_reg == S_DEC) begin
      dec_reg <= dec_now;
    end
  end

  // Memory wait counter: cleared on entry to a memory state, counts unacked cycles
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wait_reg <= '0;
    end else if ((state_next != state_reg) &&
                 ((state_next == S_IF) || (state_next == S_MEM))) begin
      wait_reg <= '0;
    end else if (in_mem_wait && !Mem_Ack) begin
      wait_reg <= wait_reg + CW'(1);
    end
  end

  // Sticky error flag and cause, captured on the transition into S_ERR
  always_ff @(posedge Clk) begin
    if (Reset) begin
      error_reg    <= 1'b0;
      err_code_reg <= ERR_NONE;
    end else if ((state_reg != S_ERR) && (state_next == S_ERR)) begin
      error_reg    <= 1'b1;
      err_code_reg <= (state_reg == S_DEC) ? ERR_ILLEGAL : ERR_TIMEOUT;
    end
  end

  // Output decode from state and latched instruction; Reset forces all outputs low
  always_comb begin
    Mem_Req       = 1'b0;
    Mem_WrEn      = 1'b0;
    Instr_LdEn    = 1'b0;
    PC_LdEn       = 1'b0;
    PC_sel        = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ImmExt_sel    = 1'b0;
    ALU_func      = ALU_ADD;
    Error         = error_reg;
    Err_code      = err_code_reg;
    case (state_reg)
      S_IF: begin
        Mem_Req    = 1'b1;
        Instr_LdEn = Mem_Ack;
      end
      S_EXE: begin
        ALU_func    = dec_reg.alu_func;
        ALU_Bin_sel = dec_reg.alu_bin_sel;
        ImmExt_sel  = dec_reg.imm_ext_sel;
      end
      S_MEM: begin
        Mem_Req  = 1'b1;
        Mem_WrEn = (dec_reg.cls == CLS_SW);
        ALU_func = dec_reg.alu_func;
        PC_LdEn  = Mem_Ack && (dec_reg.cls == CLS_SW);
      end
      S_WB: begin
        RF_WrEn       = 1'b1;
        RF_WrData_sel = (dec_reg.cls == CLS_LW);
        PC_LdEn       = 1'b1;
      end
      S_BR: begin
        ALU_func = dec_reg.alu_func;
        RF_B_sel = 1'b1;
        PC_LdEn  = 1'b1;
        PC_sel   = branch_taken;
      end
      default: ;
    endcase
    if (Reset) begin
      Mem_Req       = 1'b0;
      Mem_WrEn      = 1'b0;
      Instr_LdEn    = 1'b0;
      PC_LdEn       = 1'b0;
      PC_sel        = 1'b0;
      RF_WrEn       = 1'b0;
      RF_WrData_sel = 1'b0;
      RF_B_sel      = 1'b0;
      ALU_Bin_sel   = 1'b0;
      ImmExt_sel    = 1'b0;
      ALU_func      = 4'b0000;
      Error         = 1'b0;
      Err_code      = 2'b00;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle output vectors checked
// against hand-written expectations for each instruction class and error path.
module tb_multicycle_control;

  logic        Clk;
  logic        Reset;
  logic [31:0] Instr;
  logic        Zero;
  logic        Mem_Ack;
  logic        Mem_Req, Mem_WrEn, Instr_LdEn, PC_LdEn, PC_sel;
  logic        RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel, ImmExt_sel;
  logic [3:0]  ALU_func;
  logic        Error;
  logic [1:0]  Err_code;

  int vectors     = 0;
  int miscompares = 0;

  // Output vector layout used by every expectation below
  localparam logic [16:0] REQ  = 17'h10000;
  localparam logic [16:0] WR   = 17'h08000;
  localparam logic [16:0] ILD  = 17'h04000;
  localparam logic [16:0] PCL  = 17'h02000;
  localparam logic [16:0] PCS  = 17'h01000;
  localparam logic [16:0] RFW  = 17'h00800;
  localparam logic [16:0] RFD  = 17'h00400;
  localparam logic [16:0] RBS  = 17'h00200;
  localparam logic [16:0] BIN  = 17'h00100;
  localparam logic [16:0] IMX  = 17'h00080;
  localparam logic [16:0] ERR  = 17'h00004;
  localparam logic [16:0] EC01 = 17'h00001;
  localparam logic [16:0] EC10 = 17'h00002;
  localparam logic [16:0] NONE = 17'h00000;

  logic [16:0] outs;
  assign outs = {Mem_Req, Mem_WrEn, Instr_LdEn, PC_LdEn, PC_sel, RF_WrEn,
                 RF_WrData_sel, RF_B_sel, ALU_Bin_sel, ImmExt_sel, ALU_func,
                 Error, Err_code};

  function automatic logic [16:0] alu(input logic [3:0] c);
    return {10'b0, c, 3'b000};
  endfunction

  multicycle_control #(.MEM_TIMEOUT(16)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Instr         (Instr),
    .Zero          (Zero),
    .Mem_Ack       (Mem_Ack),
    .Mem_Req       (Mem_Req),
    .Mem_WrEn      (Mem_WrEn),
    .Instr_LdEn    (Instr_LdEn),
    .PC_LdEn       (PC_LdEn),
    .PC_sel        (PC_sel),
    .RF_WrEn       (RF_WrEn),
    .RF_WrData_sel (RF_WrData_sel),
    .RF_B_sel      (RF_B_sel),
    .ALU_Bin_sel   (ALU_Bin_sel),
    .ImmExt_sel    (ImmExt_sel),
    .ALU_func      (ALU_func),
    .Error         (Error),
    .Err_code      (Err_code)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Mem_Ack = 1'b1; Zero = 1'b0; Instr = 32'h8000_0030;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      vectors++;
      if (outs !== NONE) begin
        miscompares++;
        $display("FAIL reset cyc%0d: got %05h want %05h", i, outs, NONE);
      end
    end
    Reset = 1'b0; Mem_Ack = 1'b0;
    #1;
    vectors++;
    if (outs !== REQ) begin
      miscompares++;
      $display("FAIL reset_release: got %05h want %05h", outs, REQ);
    end
    tick();
    $display("txn reset: 3 cycles then release");
  endtask

  task automatic test_add();
    logic [16:0] exp [4];
    exp = '{REQ | ILD, NONE, alu(4'b0000), RFW | PCL};
    Instr = 32'h8000_0030; Mem_Ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (outs !== exp[i]) begin
        miscompares++;
        $display("FAIL add cyc%0d: got %05h want %05h", i, outs, exp[i]);
      end
      tick();
    end
    $display("txn add 0x80000030: IF DEC EXE WB");
  endtask

  task automatic test_rtype_funcs();
    logic [3:0]  codes [10];
    logic [16:0] exp [4];
    codes = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA, 4'hC, 4'hD};
    Mem_Ack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      Instr = {6'b100000, 20'h0, 2'b11, codes[k]};
      exp = '{REQ | ILD, NONE, alu(codes[k]), RFW | PCL};
      for (int i = 0; i < 4; i++) begin
        #1;
        vectors++;
        if (outs !== exp[i]) begin
          miscompares++;
          $display("FAIL rtype_%h cyc%0d: got %05h want %05h", codes[k], i, outs, exp[i]);
        end
        tick();
      end
      $display("txn rtype func=11%b", codes[k]);
    end
  endtask

  task automatic test_immediate();
    logic [31:0] ins [4];
    logic [16:0] exe [4];
    logic [16:0] exp [4];
    ins = '{32'hC800_0000, 32'hCC00_0000, 32'hC000_0000, 32'hE000_0000};
    exe = '{alu(4'b0010) | IMX | BIN, alu(4'b0011) | IMX | BIN, BIN, BIN};
    Mem_Ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      Instr = ins[k];
      exp = '{REQ | ILD, NONE, exe[k], RFW | PCL};
      for (int i = 0; i < 4; i++) begin
        #1;
        vectors++;
        if (outs !== exp[i]) begin
          miscompares++;
          $display("FAIL imm_%08h cyc%0d: got %05h want %05h", ins[k], i, outs, exp[i]);
        end
        tick();
      end
      $display("txn immediate instr=%08h", ins[k]);
    end
  endtask

  task automatic test_branch();
    logic [31:0] ins [6];
    logic        zs  [6];
    logic        tk  [6];
    logic [16:0] exp [3];
    ins = '{32'h0000_0000, 32'h0000_0000, 32'h0400_0000, 32'h0400_0000,
            32'hFC00_0000, 32'hFC00_0000};
    zs  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tk  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    Mem_Ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      Instr = ins[k]; Zero = zs[k];
      exp = '{REQ | ILD, NONE, alu(4'b0001) | RBS | PCL | (tk[k] ? PCS : NONE)};
      for (int i = 0; i < 3; i++) begin
        #1;
        vectors++;
        if (outs !== exp[i]) begin
          miscompares++;
          $display("FAIL branch%0d cyc%0d: got %05h want %05h", k, i, outs, exp[i]);
        end
        tick();
      end
      $display("txn branch instr=%08h zero=%0b", ins[k], zs[k]);
    end
    Zero = 1'b0;
  endtask

  task automatic test_load_store();
    logic [16:0] lw_exp [8];
    logic        lw_ack [8];
    logic [16:0] sw_exp [4];
    lw_exp = '{REQ | ILD, NONE, BIN, REQ, REQ, REQ, REQ, RFW | RFD | PCL};
    lw_ack = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    Instr = 32'h3C00_0000;
    for (int i = 0; i < 8; i++) begin
      Mem_Ack = lw_ack[i];
      #1;
      vectors++;
      if (outs !== lw_exp[i]) begin
        miscompares++;
        $display("FAIL lw cyc%0d: got %05h want %05h", i, outs, lw_exp[i]);
      end
      tick();
    end
    $display("txn lw with 3 wait cycles");
    sw_exp = '{REQ | ILD, NONE, BIN, REQ | WR | PCL};
    Instr = 32'h7C00_0000; Mem_Ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (outs !== sw_exp[i]) begin
        miscompares++;
        $display("FAIL sw cyc%0d: got %05h want %05h", i, outs, sw_exp[i]);
      end
      tick();
    end
    $display("txn sw zero-wait");
  endtask

  task automatic test_illegal();
    logic [31:0] ins [2];
    logic [16:0] exp [5];
    ins = '{32'h8000_0035, 32'hA800_0000};
    exp = '{REQ | ILD, NONE, ERR | EC01, ERR | EC01, ERR | EC01};
    for (int k = 0; k < 2; k++) begin
      Instr = ins[k]; Mem_Ack = 1'b1;
      for (int i = 0; i < 5; i++) begin
        #1;
        vectors++;
        if (outs !== exp[i]) begin
          miscompares++;
          $display("FAIL illegal%0d cyc%0d: got %05h want %05h", k, i, outs, exp[i]);
        end
        tick();
      end
      Reset = 1'b1;
      #1;
      vectors++;
      if (outs !== NONE) begin
        miscompares++;
        $display("FAIL illegal%0d_reset: got %05h want %05h", k, outs, NONE);
      end
      tick();
      Reset = 1'b0;
      $display("txn illegal instr=%08h", ins[k]);
    end
  endtask

  task automatic test_timeout();
    // Fetch never acked: 16 request cycles then the timeout error
    Mem_Ack = 1'b0;
    for (int i = 0; i < 18; i++) begin
      #1;
      vectors++;
      if (outs !== ((i < 16) ? REQ : (ERR | EC10))) begin
        miscompares++;
        $display("FAIL if_timeout cyc%0d: got %05h want %05h", i, outs,
                 (i < 16) ? REQ : (ERR | EC10));
      end
      tick();
    end
    $display("txn fetch timeout");
    Reset = 1'b1; tick(); Reset = 1'b0;
    // Ack on the terminal wait cycle is accepted without error
    Instr = 32'h8000_0030;
    for (int i = 0; i < 19; i++) begin
      Mem_Ack = (i >= 15);
      #1;
      vectors++;
      if (outs !== ((i < 15) ? REQ : (i == 15) ? (REQ | ILD) : (i == 18) ? (RFW | PCL) : NONE)) begin
        miscompares++;
        $display("FAIL if_terminal_ack cyc%0d: got %05h want %05h", i, outs,
                 (i < 15) ? REQ : (i == 15) ? (REQ | ILD) : (i == 18) ? (RFW | PCL) : NONE);
      end
      tick();
    end
    $display("txn fetch ack on terminal cycle");
    // lw whose data access is never acked
    Instr = 32'h3C00_0000;
    for (int i = 0; i < 20; i++) begin
      Mem_Ack = (i < 3);
      #1;
      vectors++;
      if (outs !== ((i == 0) ? (REQ | ILD) : (i == 1) ? NONE : (i == 2) ? BIN :
                    (i < 19) ? REQ : (ERR | EC10))) begin
        miscompares++;
        $display("FAIL mem_timeout cyc%0d: got %05h want %05h", i, outs,
                 (i == 0) ? (REQ | ILD) : (i == 1) ? NONE : (i == 2) ? BIN :
                 (i < 19) ? REQ : (ERR | EC10));
      end
      tick();
    end
    $display("txn lw data timeout");
    Reset = 1'b1; tick(); Reset = 1'b0;
  endtask

  task automatic test_reset_in_mem();
    logic [16:0] exp [4];
    exp = '{REQ | ILD, NONE, BIN, REQ | WR};
    Instr = 32'h7C00_0000;
    for (int i = 0; i < 4; i++) begin
      Mem_Ack = (i < 3);
      #1;
      vectors++;
      if (outs !== exp[i]) begin
        miscompares++;
        $display("FAIL sw_abort cyc%0d: got %05h want %05h", i, outs, exp[i]);
      end
      tick();
    end
    Reset = 1'b1;
    #1;
    vectors++;
    if (outs !== NONE) begin
      miscompares++;
      $display("FAIL sw_abort_reset: got %05h want %05h", outs, NONE);
    end
    tick();
    Reset = 1'b0;
    #1;
    vectors++;
    if (outs !== REQ) begin
      miscompares++;
      $display("FAIL sw_abort_after: got %05h want %05h", outs, REQ);
    end
    tick();
    $display("txn sw aborted by reset in S_MEM");
  endtask

  initial begin
    Reset = 1'b1; Instr = '0; Zero = 1'b0; Mem_Ack = 1'b0;
    test_reset();
    test_add();
    test_rtype_funcs();
    test_immediate();
    test_branch();
    test_load_store();
    test_illegal();
    test_timeout();
    test_reset_in_mem();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
